// File: rtl/serial_addsub_digit_pkg.sv
// Shared types for the serial digit adder/subtractor.
// Word state, per-word mode, beat counter width helper.
package serial_arith_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  function automatic int cnt_w(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/serial_addsub_digit_if.sv
// Operand/result stream bundle for serial_addsub_digit.
// master drives digits, slave (the adder) returns results.
interface serial_addsub_digit_if #(
  parameter int DIGIT_W = 4
);

  logic               vld;
  logic [DIGIT_W-1:0] a;
  logic [DIGIT_W-1:0] b;
  logic               last;
  logic               sub;

  logic               out_vld;
  logic [DIGIT_W-1:0] out_sum;
  logic               out_last;
  logic               out_carry;
  logic               out_ovf;
  logic               out_err;

  modport master (
    output vld, a, b, last, sub,
    input  out_vld, out_sum, out_last,
    input  out_carry, out_ovf, out_err
  );

  modport slave (
    input  vld, a, b, last, sub,
    output out_vld, out_sum, out_last,
    output out_carry, out_ovf, out_err
  );

endinterface

// File: rtl/serial_addsub_digit_cell.sv
// One-digit adder with optional B inversion (combinational).
// Ports: a_i, b_i, inv_b_i, c_in_i -> s_o, c_out_o, c_msb_in_o.
module serial_addsub_digit_cell #(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] a_i,
  input  logic [DIGIT_W-1:0] b_i,
  input  logic               inv_b_i,
  input  logic               c_in_i,
  output logic [DIGIT_W-1:0] s_o,
  output logic               c_out_o,
  output logic               c_msb_in_o
);

  logic [DIGIT_W-1:0] bx;
  logic [DIGIT_W:0]   full;

  assign bx   = inv_b_i ? ~b_i : b_i;
  assign full = {1'b0, a_i}
              + {1'b0, bx}
              + {{DIGIT_W{1'b0}}, c_in_i};

  assign s_o     = full[DIGIT_W-1:0];
  assign c_out_o = full[DIGIT_W];

  // Carry into the MSB recovered from the MSB sum bit;
  // also correct for DIGIT_W == 1 (equals c_in).
  assign c_msb_in_o = full[DIGIT_W-1]
                    ^ a_i[DIGIT_W-1]
                    ^ bx[DIGIT_W-1];

endmodule

// File: rtl/serial_addsub_digit.sv
// Serial two's-complement add/sub, LSB digit first, 1-cycle latency.
// Ports: clk, rst (sync, active-high), bus (slave stream bundle).
module serial_addsub_digit
  import serial_arith_pkg::*;
#(
  parameter int DIGIT_W   = 4,
  parameter int MAX_BEATS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_addsub_digit_if.slave  bus
);

  localparam int CW = cnt_w(MAX_BEATS);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic               carry_q, carry_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               vld_q, vld_d;
  logic [DIGIT_W-1:0] sum_q, sum_d;
  logic               last_q, last_d;
  logic               cy_q, cy_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;

  logic               first;
  mode_e              mode_eff;
  logic               c_in;
  logic               close;
  logic [DIGIT_W-1:0] s;
  logic               c_out;
  logic               c_msb;

  // First beat of a word samples sub for mode and carry-in.
  assign first    = (state_q == IDLE);
  assign mode_eff = first ? mode_e'(bus.sub) : mode_q;
  assign c_in     = first ? bus.sub : carry_q;
  assign close    = bus.last | (cnt_q == LAST_CNT);

  serial_addsub_digit_cell #(
    .DIGIT_W (DIGIT_W)
  ) u_cell (
    .a_i        (bus.a),
    .b_i        (bus.b),
    .inv_b_i    (mode_eff == MODE_SUB),
    .c_in_i     (c_in),
    .s_o        (s),
    .c_out_o    (c_out),
    .c_msb_in_o (c_msb)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    vld_d   = 1'b0;
    sum_d   = '0;
    last_d  = 1'b0;
    cy_d    = 1'b0;
    ovf_d   = 1'b0;
    err_d   = 1'b0;
    if (bus.vld) begin
      mode_d = mode_eff;
      vld_d  = 1'b1;
      sum_d  = s;
      if (close) begin
        state_d = IDLE;
        carry_d = 1'b0;
        cnt_d   = '0;
        last_d  = 1'b1;
        cy_d    = c_out;
        ovf_d   = c_out ^ c_msb;
        err_d   = ~bus.last;
      end else begin
        state_d = ACTIVE;
        carry_d = c_out;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_ADD;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      sum_q   <= '0;
      last_q  <= 1'b0;
      cy_q    <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      sum_q   <= sum_d;
      last_q  <= last_d;
      cy_q    <= cy_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign bus.out_vld   = vld_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_last  = last_q;
  assign bus.out_carry = cy_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_err   = err_q;

endmodule
